// File: rtl/lfu_pkg.sv
// rtl/lfu_pkg.sv - shared constants and helpers for the LFU replacement engine
package lfu_pkg;

    localparam int DEF_NUM_ENT = 4;
    localparam int DEF_CNT_W   = 4;

    // Largest value an access counter of width w can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Victim key: count in the upper bits, recency rank below, so an unsigned
    // compare orders by count first and least-recent use second.
    function automatic logic [31:0] pack_key(input logic [31:0] cnt,
                                             input logic [31:0] rank,
                                             input int          rank_w);
        return (cnt << rank_w) | rank;
    endfunction

endpackage

// File: rtl/lfu_min_sel.sv
// rtl/lfu_min_sel.sv - balanced comparator tree returning the minimum-key entry
import lfu_pkg::*;

module lfu_min_sel #(
    parameter int NUM_ENT = DEF_NUM_ENT,
    parameter int KEY_W   = DEF_CNT_W + $clog2(DEF_NUM_ENT)
) (
    input  logic [NUM_ENT*KEY_W-1:0]                 keys,
    output logic [$clog2(NUM_ENT)-1:0]               min_idx,
    output logic [KEY_W-$clog2(NUM_ENT)-1:0]         min_cnt
);

    localparam int IDX_W = $clog2(NUM_ENT);
    localparam int CNT_W = KEY_W - IDX_W;
    localparam int NODES = 2 * NUM_ENT - 1;

    // Heap layout: node n has children 2n+1 and 2n+2, leaves sit at NUM_ENT-1+i.
    logic [KEY_W-1:0] node_key [NODES];
    logic [IDX_W-1:0] node_idx [NODES];

    // Reduce leaves pairwise towards the root; keys are unique so ties never occur.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            node_key[n] = '0;
            node_idx[n] = '0;
        end
        for (int i = 0; i < NUM_ENT; i++) begin
            node_key[NUM_ENT-1+i] = keys[i*KEY_W +: KEY_W];
            node_idx[NUM_ENT-1+i] = IDX_W'(i);
        end
        for (int n = NUM_ENT - 2; n >= 0; n--) begin
            if (node_key[2*n+1] <= node_key[2*n+2]) begin
                node_key[n] = node_key[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end else begin
                node_key[n] = node_key[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end
        end
    end

    assign min_idx = node_idx[0];
    assign min_cnt = node_key[0][KEY_W-1 -: CNT_W];

endmodule

// File: rtl/lfu_repl_engine.sv
// rtl/lfu_repl_engine.sv - LFU victim tracker with recency tie-break and counter aging
import lfu_pkg::*;

module lfu_repl_engine #(
    parameter int NUM_ENT = DEF_NUM_ENT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acc_vld,
    input  logic [$clog2(NUM_ENT)-1:0] acc_idx,
    input  logic                       new_req,
    output logic [$clog2(NUM_ENT)-1:0] victim_idx,
    output logic [CNT_W-1:0]           victim_cnt,
    output logic                       age_pulse,
    output logic                       acc_drop
);

    localparam int IDX_W = $clog2(NUM_ENT);
    localparam int KEY_W = CNT_W + IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] AGE_VAL = CNT_W'((cnt_max(CNT_W) >> 1) + 1);

    logic [CNT_W-1:0] cnt_q  [NUM_ENT];
    logic [CNT_W-1:0] cnt_d  [NUM_ENT];
    logic [IDX_W-1:0] rank_q [NUM_ENT];
    logic [IDX_W-1:0] rank_d [NUM_ENT];

    logic [IDX_W-1:0] victim_idx_q, victim_idx_d;
    logic [CNT_W-1:0] victim_cnt_q, victim_cnt_d;
    logic             age_pulse_q, age_pulse_d;
    logic             acc_drop_q, acc_drop_d;

    logic             touch_en;
    logic [IDX_W-1:0] touch_e;
    logic [NUM_ENT*KEY_W-1:0] keys_d;

    // Next-state counters and ranks: refill beats access, saturation triggers aging.
    always_comb begin
        cnt_d       = cnt_q;
        rank_d      = rank_q;
        age_pulse_d = 1'b0;
        acc_drop_d  = 1'b0;
        touch_en    = 1'b0;
        touch_e     = '0;
        keys_d      = '0;

        if (new_req) begin
            cnt_d[victim_idx_q] = CNT_W'(1);
            touch_en            = 1'b1;
            touch_e             = victim_idx_q;
            acc_drop_d          = acc_vld;
        end else if (acc_vld) begin
            touch_en = 1'b1;
            touch_e  = acc_idx;
            if (cnt_q[acc_idx] != CNT_MAX) begin
                cnt_d[acc_idx] = cnt_q[acc_idx] + CNT_W'(1);
            end else begin
                for (int i = 0; i < NUM_ENT; i++) begin
                    cnt_d[i] = cnt_q[i] >> 1;
                end
                cnt_d[acc_idx] = AGE_VAL;
                age_pulse_d    = 1'b1;
            end
        end

        if (touch_en) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (rank_q[i] > rank_q[touch_e]) begin
                    rank_d[i] = rank_q[i] - IDX_W'(1);
                end
            end
            rank_d[touch_e] = IDX_W'(NUM_ENT - 1);
        end

        for (int i = 0; i < NUM_ENT; i++) begin
            keys_d[i*KEY_W +: KEY_W] = KEY_W'(pack_key(32'(cnt_d[i]), 32'(rank_d[i]), IDX_W));
        end
    end

    lfu_min_sel #(
        .NUM_ENT (NUM_ENT),
        .KEY_W   (KEY_W)
    ) u_min_sel (
        .keys    (keys_d),
        .min_idx (victim_idx_d),
        .min_cnt (victim_cnt_d)
    );

    // State and registered outputs; entry 0 starts as the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                cnt_q[i]  <= CNT_W'(1);
                rank_q[i] <= IDX_W'(i);
            end
            victim_idx_q <= '0;
            victim_cnt_q <= CNT_W'(1);
            age_pulse_q  <= 1'b0;
            acc_drop_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rank_q       <= rank_d;
            victim_idx_q <= victim_idx_d;
            victim_cnt_q <= victim_cnt_d;
            age_pulse_q  <= age_pulse_d;
            acc_drop_q   <= acc_drop_d;
        end
    end

    assign victim_idx = victim_idx_q;
    assign victim_cnt = victim_cnt_q;
    assign age_pulse  = age_pulse_q;
    assign acc_drop   = acc_drop_q;

endmodule

// File: tb/tb_lfu_repl_engine.sv
// tb/tb_lfu_repl_engine.sv - self-checking bench for lfu_repl_engine
module tb_lfu_repl_engine;

    localparam int N     = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       acc_vld = 1'b0;
    logic [1:0] acc_idx = 2'd0;
    logic       new_req = 1'b0;
    logic [1:0] victim_idx;
    logic [3:0] victim_cnt;
    logic       age_pulse;
    logic       acc_drop;

    int n_chk  = 0;
    int n_fail = 0;

    lfu_repl_engine #(.NUM_ENT(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_vld    (acc_vld),
        .acc_idx    (acc_idx),
        .new_req    (new_req),
        .victim_idx (victim_idx),
        .victim_cnt (victim_cnt),
        .age_pulse  (age_pulse),
        .acc_drop   (acc_drop)
    );

    always #5 clk = ~clk;

    // Reference model: counts per entry plus a recency list (oldest first).
    int m_cnt [N];
    int order [$];
    int m_vidx, m_vcnt, m_age, m_drop;

    function automatic int rank_of(input int e);
        for (int k = 0; k < order.size(); k++) if (order[k] == e) return k;
        return -1;
    endfunction

    task automatic m_touch(input int e);
        int p;
        p = rank_of(e);
        order.delete(p);
        order.push_back(e);
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 1;
        order = {};
        for (int i = 0; i < N; i++) order.push_back(i);
        m_vidx = 0; m_vcnt = 1; m_age = 0; m_drop = 0;
    endtask

    task automatic m_step(input int av, input int ai, input int nr);
        int best;
        m_age = 0; m_drop = 0;
        if (nr != 0) begin
            m_cnt[m_vidx] = 1;
            m_touch(m_vidx);
            m_drop = av;
        end else if (av != 0) begin
            if (m_cnt[ai] < CMAX) begin
                m_cnt[ai] = m_cnt[ai] + 1;
            end else begin
                for (int i = 0; i < N; i++) m_cnt[i] = m_cnt[i] / 2;
                m_cnt[ai] = CMAX / 2 + 1;
                m_age = 1;
            end
            m_touch(ai);
        end
        best = 0;
        for (int i = 1; i < N; i++)
            if (m_cnt[i] < m_cnt[best] || (m_cnt[i] == m_cnt[best] && rank_of(i) < rank_of(best)))
                best = i;
        m_vidx = best;
        m_vcnt = m_cnt[best];
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " victim_idx"}, int'(victim_idx), m_vidx);
        chk({tag, " victim_cnt"}, int'(victim_cnt), m_vcnt);
        chk({tag, " age_pulse"},  int'(age_pulse),  m_age);
        chk({tag, " acc_drop"},   int'(acc_drop),   m_drop);
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the rising edge.
    task automatic step(input int av, input int ai, input int nr);
        acc_vld = av[0];
        acc_idx = 2'(ai);
        new_req = nr[0];
        @(posedge clk);
        #1;
        m_step(av, ai, nr);
        acc_vld = 1'b0;
        new_req = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        m_reset();
    endtask

    typedef struct {
        int av; int ai; int nr;
        int e_vidx; int e_vcnt; int e_age; int e_drop;
    } vec_t;

    vec_t vt [6];

    initial begin
        int hot;
        vt[0] = '{1, 0, 0, 1, 1, 0, 0};
        vt[1] = '{0, 0, 1, 2, 1, 0, 0};
        vt[2] = '{1, 3, 1, 3, 1, 0, 1};
        vt[3] = '{0, 0, 0, 3, 1, 0, 0};
        vt[4] = '{1, 3, 0, 1, 1, 0, 0};
        vt[5] = '{1, 1, 0, 2, 1, 0, 0};

        m_reset();
        do_reset();
        chk("reset victim_idx", int'(victim_idx), 0);
        chk("reset victim_cnt", int'(victim_cnt), 1);
        chk("reset age_pulse",  int'(age_pulse),  0);
        chk("reset acc_drop",   int'(acc_drop),   0);

        for (int k = 0; k < 6; k++) begin
            step(vt[k].av, vt[k].ai, vt[k].nr);
            chk($sformatf("vec%0d victim_idx", k), int'(victim_idx), vt[k].e_vidx);
            chk($sformatf("vec%0d victim_cnt", k), int'(victim_cnt), vt[k].e_vcnt);
            chk($sformatf("vec%0d age_pulse", k),  int'(age_pulse),  vt[k].e_age);
            chk($sformatf("vec%0d acc_drop", k),   int'(acc_drop),   vt[k].e_drop);
        end

        // Collision straight out of reset: entry 0 refilled, access to 3 dropped.
        do_reset();
        step(1, 3, 1);
        chk("collide acc_drop",   int'(acc_drop),   1);
        chk("collide victim_idx", int'(victim_idx), 1);
        chk("collide victim_cnt", int'(victim_cnt), 1);
        step(0, 0, 0);
        chk("collide drop clears", int'(acc_drop), 0);

        // Aging: 14 hits saturate entry 2, the 15th halves everything.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            step(1, 2, 0);
            chk_model("pre-age");
        end
        chk("pre-age no pulse", int'(age_pulse), 0);
        step(1, 2, 0);
        chk("age pulse",      int'(age_pulse),  1);
        chk("age victim_idx", int'(victim_idx), 0);
        chk("age victim_cnt", int'(victim_cnt), 0);
        step(0, 0, 0);
        chk("age pulse clears", int'(age_pulse), 0);
        step(1, 0, 0);
        chk_model("post-age");

        // Asynchronous reset between edges.
        step(1, 1, 0);
        step(1, 3, 0);
        step(0, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("async victim_idx", int'(victim_idx), 0);
        chk("async victim_cnt", int'(victim_cnt), 1);
        chk("async age_pulse",  int'(age_pulse),  0);
        chk("async acc_drop",   int'(acc_drop),   0);
        @(posedge clk);
        #2 rst = 1'b0;
        m_reset();
        step(1, 0, 0);
        chk("after reset victim_idx", int'(victim_idx), 1);
        chk("after reset victim_cnt", int'(victim_cnt), 1);

        // Randomized traffic with a hot entry so aging fires regularly.
        hot = 2;
        for (int k = 0; k < 600; k++) begin
            int av, ai, nr;
            if (k % 150 == 0) hot = int'($urandom_range(0, N - 1));
            av = ($urandom_range(0, 99) < 80) ? 1 : 0;
            ai = ($urandom_range(0, 99) < 60) ? hot : int'($urandom_range(0, N - 1));
            nr = ($urandom_range(0, 99) < 15) ? 1 : 0;
            step(av, ai, nr);
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
